// File: rtl/basket_controller_if.sv
// Request/response and read-port bundle between the sale terminal and the basket store.
interface basket_controller_if #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned QTY_W = 4
);
  logic             Enable;
  logic             Cancel;
  logic             Clear;
  logic [ID_W-1:0]  ProductID_in;
  logic [QTY_W-1:0] ProductQuantity;
  logic [ID_W-1:0]  Rd_index;
  logic [ID_W-1:0]  Rd_ProductID;
  logic [QTY_W-1:0] Rd_Quantity;
  logic [3:0]       BasketProductNum;
  logic             Busy;
  logic             Op_done;
  logic             Op_error;
  logic             Qty_saturated;

  // Upstream terminal / display side
  modport master (
    output Enable, Cancel, Clear, ProductID_in, ProductQuantity, Rd_index,
    input  Rd_ProductID, Rd_Quantity, BasketProductNum, Busy, Op_done, Op_error, Qty_saturated
  );

  // Basket store side
  modport slave (
    input  Enable, Cancel, Clear, ProductID_in, ProductQuantity, Rd_index,
    output Rd_ProductID, Rd_Quantity, BasketProductNum, Busy, Op_done, Op_error, Qty_saturated
  );
endinterface

// File: rtl/basket_controller.sv
// Ordered basket of (product ID, quantity) entries with add/merge, cancel/compact and clear.
module basket_controller #(
  parameter int unsigned MAX_ITEMS = 8,
  parameter int unsigned MAX_QTY   = 15,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned QTY_W     = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  basket_controller_if.slave   bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = QTY_W + 1;
  localparam logic [ID_W-1:0] BLANK_ID = '1;

  typedef enum logic [2:0] {IDLE, SEARCH, MERGE, APPEND, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q  [MAX_ITEMS];
  logic [QTY_W-1:0] qty_q [MAX_ITEMS];
  logic [CNT_W-1:0] count_q;
  logic [ID_W-1:0]  idx_q;
  logic [ID_W-1:0]  lat_id_q;
  logic [QTY_W-1:0] lat_qty_q;
  logic             busy_q, done_q, err_q, sat_q;

  logic             done_d, err_d, sat_d;
  logic             do_clear, do_latch, do_cancel, do_merge, do_append, do_move, do_final, idx_inc;
  logic [ID_W-1:0]  cur_id, rd_id;
  logic [QTY_W-1:0] cur_qty, rd_qty;
  logic [SUM_W-1:0] sum;
  logic             clip;
  logic [QTY_W-1:0] merged_qty;
  logic             at_end, at_last, full;

  // Entry selected by the working index, and the read-port view (blank past count)
  always_comb begin
    cur_id  = BLANK_ID;
    cur_qty = '0;
    rd_id   = BLANK_ID;
    rd_qty  = '0;
    for (int unsigned j = 0; j < MAX_ITEMS; j++) begin
      if (32'(idx_q) == j) begin
        cur_id  = id_q[j];
        cur_qty = qty_q[j];
      end
      if (32'(bus.Rd_index) == j && j < 32'(count_q)) begin
        rd_id  = id_q[j];
        rd_qty = qty_q[j];
      end
    end
  end

  assign sum        = SUM_W'(cur_qty) + SUM_W'(lat_qty_q);
  assign clip       = sum > SUM_W'(MAX_QTY);
  assign merged_qty = clip ? QTY_W'(MAX_QTY) : sum[QTY_W-1:0];
  assign at_end     = 32'(idx_q) == 32'(count_q);
  assign at_last    = (32'(idx_q) + 32'd1) == 32'(count_q);
  assign full       = 32'(count_q) >= MAX_ITEMS;

  // Next state and one-cycle datapath controls; Clear wins over everything
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sat_d     = 1'b0;
    do_clear  = 1'b0;
    do_latch  = 1'b0;
    do_cancel = 1'b0;
    do_merge  = 1'b0;
    do_append = 1'b0;
    do_move   = 1'b0;
    do_final  = 1'b0;
    idx_inc   = 1'b0;
    if (bus.Clear) begin
      do_clear = 1'b1;
      done_d   = 1'b1;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Cancel) begin
            if (32'(bus.ProductID_in) >= 32'(count_q)) begin
              err_d = 1'b1;
            end else begin
              do_cancel = 1'b1;
              state_d   = SHIFT;
            end
          end else if (bus.Enable) begin
            if (bus.ProductID_in == BLANK_ID || bus.ProductQuantity == '0) begin
              err_d = 1'b1;
            end else begin
              do_latch = 1'b1;
              state_d  = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (at_end)                  state_d = APPEND;
          else if (cur_id == lat_id_q) state_d = MERGE;
          else                         idx_inc = 1'b1;
        end
        MERGE: begin
          do_merge = 1'b1;
          sat_d    = clip;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        APPEND: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            do_append = 1'b1;
            done_d    = 1'b1;
          end
          state_d = IDLE;
        end
        SHIFT: begin
          if (at_last) begin
            do_final = 1'b1;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            do_move = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // Requests that arrive while an operation is in flight are dropped
      if (state_q != IDLE && (bus.Enable || bus.Cancel)) err_d = 1'b1;
    end
  end

  // State, status pulses and basket storage
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      lat_id_q  <= '0;
      lat_qty_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      for (int unsigned j = 0; j < MAX_ITEMS; j++) begin
        id_q[j]  <= BLANK_ID;
        qty_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      if (do_clear) begin
        count_q <= '0;
        for (int unsigned j = 0; j < MAX_ITEMS; j++) begin
          id_q[j]  <= BLANK_ID;
          qty_q[j] <= '0;
        end
      end else begin
        if (do_latch) begin
          lat_id_q  <= bus.ProductID_in;
          lat_qty_q <= bus.ProductQuantity;
          idx_q     <= '0;
        end
        if (do_cancel) idx_q <= bus.ProductID_in;
        if (idx_inc || do_move) idx_q <= idx_q + ID_W'(1);
        if (do_append) count_q <= count_q + CNT_W'(1);
        if (do_final)  count_q <= count_q - CNT_W'(1);
        for (int unsigned j = 0; j < MAX_ITEMS; j++) begin
          if (do_merge && 32'(idx_q) == j) qty_q[j] <= merged_qty;
          if (do_append && 32'(count_q) == j) begin
            id_q[j]  <= lat_id_q;
            qty_q[j] <= lat_qty_q;
          end
          if (do_final && 32'(idx_q) == j) begin
            id_q[j]  <= BLANK_ID;
            qty_q[j] <= '0;
          end
        end
        for (int unsigned j = 0; j + 1 < MAX_ITEMS; j++) begin
          if (do_move && 32'(idx_q) == j) begin
            id_q[j]  <= id_q[j+1];
            qty_q[j] <= qty_q[j+1];
          end
        end
      end
    end
  end

  assign bus.Rd_ProductID     = rd_id;
  assign bus.Rd_Quantity      = rd_qty;
  assign bus.BasketProductNum = count_q;
  assign bus.Busy             = busy_q;
  assign bus.Op_done          = done_q;
  assign bus.Op_error         = err_q;
  assign bus.Qty_saturated    = sat_q;

endmodule
